spi_xfer_core: RTL and testbench

- SPI master shift engine that sits directly downstream of the mailbox SPI wrapper. It consumes the wrapper's latched command and start pulse, and returns the response word plus a ready flag.
- One transaction is a TX_LEN-byte command phase followed by an RX_LEN-byte read phase, half-duplex.
- Framing: SPI mode 0, MSB first, one chip-select line driven low, clocked entirely in the clk domain.

---
 rtl/spi_xfer_core.sv | 166 ++++++++++++++++
 tb/tb_spi_xfer_core.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_core.sv
// spi_xfer_core: SPI mode-0 master shift engine.
// Half-duplex command phase followed by a read phase under one chip select.
module spi_xfer_core #(
   parameter int TX_LEN   = 1,
   parameter int RX_LEN   = 1,
   parameter int CS_NUM   = 1,
   parameter int CS_INDEX = 0,
   parameter int SCLK_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [TX_LEN*8-1:0]   cmd,
   input  logic                  trmt,
   output logic [RX_LEN*8-1:0]   resp,
   output logic                  rx_rdy,
   input  logic                  clr_rdy,
   output logic                  busy,
   output logic                  SPI_SCLK,
   output logic                  SPI_MOSI,
   input  logic                  SPI_MISO,
   output logic [CS_NUM-1:0]     SPI_CS
);

   localparam int TXB  = TX_LEN * 8;
   localparam int RXB  = RX_LEN * 8;
   localparam int MAXB = (TXB > RXB) ? TXB : RXB;
   localparam int DW   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam int BW   = $clog2(MAXB) + 1;
   localparam logic [CS_NUM-1:0] CS_ON =
      ~(CS_NUM'(1) << CS_INDEX);

   typedef enum logic [2:0] {
      IDLE, SETUP, SHIFT_TX, SHIFT_RX, HOLD
   } state_t;

   state_t          state, state_n;
   logic [DW-1:0]   div_cnt;
   logic [BW-1:0]   bit_cnt;
   logic [TXB-1:0]  tx_sr;
   logic [RXB-1:0]  rx_sr;
   logic            last;
   logic            tx_last;
   logic            rx_last;
   logic            accept;
   logic            done;

   assign last    = (div_cnt == DW'(SCLK_DIV - 1));
   assign tx_last = (bit_cnt == BW'(TXB - 1));
   assign rx_last = (bit_cnt == BW'(RXB - 1));
   assign accept  = (state == IDLE) && !busy && trmt;
   assign done    = (state == HOLD) && last;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state: phases advance only at the end of a half-period.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:     if (busy) state_n = SETUP;
         SETUP:    if (last) state_n = SHIFT_TX;
         SHIFT_TX: if (last && SPI_SCLK && tx_last)
                      state_n = SHIFT_RX;
         SHIFT_RX: if (last && SPI_SCLK && rx_last)
                      state_n = HOLD;
         HOLD:     if (last) state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end

   // Half-period divider; held at zero while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         div_cnt <= '0;
      else if (state == IDLE || last)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DW'(1);
   end

   // Shift datapath and registered SPI pins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt  <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         resp     <= '0;
         busy     <= 1'b0;
         SPI_SCLK <= 1'b0;
         SPI_MOSI <= 1'b0;
         SPI_CS   <= '1;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  tx_sr <= cmd;
                  busy  <= 1'b1;
               end else if (busy) begin
                  SPI_CS   <= CS_ON;
                  SPI_MOSI <= tx_sr[TXB-1];
                  SPI_SCLK <= 1'b0;
                  bit_cnt  <= '0;
               end
            end
            SETUP: begin
               if (last) SPI_SCLK <= 1'b1;
            end
            SHIFT_TX: begin
               if (last) begin
                  if (!SPI_SCLK) begin
                     SPI_SCLK <= 1'b1;
                  end else begin
                     SPI_SCLK <= 1'b0;
                     if (tx_last) begin
                        SPI_MOSI <= 1'b0;
                        bit_cnt  <= '0;
                     end else begin
                        SPI_MOSI <= tx_sr[TXB-2];
                        tx_sr    <= {tx_sr[TXB-2:0], 1'b0};
                        bit_cnt  <= bit_cnt + BW'(1);
                     end
                  end
               end
            end
            SHIFT_RX: begin
               if (last) begin
                  if (!SPI_SCLK) begin
                     SPI_SCLK <= 1'b1;
                     rx_sr    <= {rx_sr[RXB-2:0], SPI_MISO};
                  end else begin
                     SPI_SCLK <= 1'b0;
                     if (!rx_last) bit_cnt <= bit_cnt + BW'(1);
                  end
               end
            end
            HOLD: begin
               if (last) begin
                  SPI_CS <= '1;
                  resp   <= rx_sr;
                  busy   <= 1'b0;
               end
            end
            default: begin
               SPI_CS   <= '1;
               SPI_SCLK <= 1'b0;
               SPI_MOSI <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

   // Sticky ready flag; completion beats a concurrent clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rx_rdy <= 1'b0;
      else if (done)
         rx_rdy <= 1'b1;
      else if (clr_rdy || accept)
         rx_rdy <= 1'b0;
   end

endmodule

// File: tb/tb_spi_xfer_core.sv
// tb_spi_xfer_core: directed bench for spi_xfer_core.
// Two instances cover the 1/1/div2/4-CS and 2/2/div1 configurations.
module tb_spi_xfer_core;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_run = 0;
   int n_fail = 0;

   // instance A: TX_LEN=1 RX_LEN=1 CS_NUM=4 CS_INDEX=2 SCLK_DIV=2
   logic [7:0]  cmd_a = 8'h00;
   logic        trmt_a = 1'b0;
   logic [7:0]  resp_a;
   logic        rx_rdy_a;
   logic        clr_a;
   logic        clr_drv = 1'b0;
   logic        tie_clr = 1'b0;
   logic        busy_a;
   logic        sclk_a;
   logic        mosi_a;
   logic        miso_a = 1'b0;
   logic [3:0]  cs_a;
   assign clr_a = tie_clr ? rx_rdy_a : clr_drv;

   // instance B: TX_LEN=2 RX_LEN=2 SCLK_DIV=1
   logic [15:0] cmd_b = 16'h0000;
   logic        trmt_b = 1'b0;
   logic [15:0] resp_b;
   logic        rx_rdy_b;
   logic        clr_b = 1'b0;
   logic        busy_b;
   logic        sclk_b;
   logic        mosi_b;
   logic        miso_b = 1'b0;
   logic [0:0]  cs_b;

   spi_xfer_core #(
      .TX_LEN(1), .RX_LEN(1), .CS_NUM(4),
      .CS_INDEX(2), .SCLK_DIV(2)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .cmd(cmd_a), .trmt(trmt_a),
      .resp(resp_a), .rx_rdy(rx_rdy_a), .clr_rdy(clr_a),
      .busy(busy_a), .SPI_SCLK(sclk_a), .SPI_MOSI(mosi_a),
      .SPI_MISO(miso_a), .SPI_CS(cs_a)
   );

   spi_xfer_core #(
      .TX_LEN(2), .RX_LEN(2), .CS_NUM(1),
      .CS_INDEX(0), .SCLK_DIV(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .cmd(cmd_b), .trmt(trmt_b),
      .resp(resp_b), .rx_rdy(rx_rdy_b), .clr_rdy(clr_b),
      .busy(busy_b), .SPI_SCLK(sclk_b), .SPI_MOSI(mosi_b),
      .SPI_MISO(miso_b), .SPI_CS(cs_b)
   );

   // SCLK rising-edge monitors: count pulses, log MOSI.
   int          rise_a = 0;
   int          rise_b = 0;
   logic [15:0] mlog_a = 16'h0;
   logic [31:0] mlog_b = 32'h0;
   always @(posedge sclk_a) begin
      rise_a = rise_a + 1;
      mlog_a = {mlog_a[14:0], mosi_a};
   end
   always @(posedge sclk_b) begin
      rise_b = rise_b + 1;
      mlog_b = {mlog_b[30:0], mosi_b};
   end

   // Slave models: present response bits on SCLK falling edges.
   logic [7:0]  mw_a = 8'h00;
   logic [15:0] mw_b = 16'h0000;
   int          nf_a = 0;
   int          nf_b = 0;
   always @(negedge sclk_a or posedge cs_a[2]) begin
      if (cs_a[2]) begin
         nf_a = 0;
         miso_a = 1'b0;
      end else begin
         nf_a = nf_a + 1;
         if (nf_a >= 8 && nf_a < 16) miso_a = mw_a[15-nf_a];
      end
   end
   always @(negedge sclk_b or posedge cs_b[0]) begin
      if (cs_b[0]) begin
         nf_b = 0;
         miso_b = 1'b0;
      end else begin
         nf_b = nf_b + 1;
         if (nf_b >= 16 && nf_b < 32) miso_b = mw_b[31-nf_b];
      end
   end

   logic cs_ok;
   logic busy_ok;
   int   rbase;

   // Run one transaction on A; lat counts cycles from trmt edge.
   task automatic xfer_a(input logic imm, input logic [7:0] c,
                         input logic [7:0] m, input int ig1,
                         input int ig2, output int lat);
      mw_a = m;
      cmd_a = c;
      cs_ok = 1'b1;
      busy_ok = 1'b1;
      if (!imm) begin
         @(posedge clk); #1;
      end
      rbase = rise_a;
      trmt_a = 1'b1;
      @(posedge clk); #1;
      trmt_a = 1'b0;
      cmd_a = 8'hFF;
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         trmt_a = (i == ig1 || i == ig2);
         if (rx_rdy_a) begin
            lat = i;
            break;
         end
         if (cs_a !== 4'b1011) cs_ok = 1'b0;
         if (busy_a !== 1'b1) busy_ok = 1'b0;
      end
      trmt_a = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_run++;
      if ({cs_a, sclk_a, mosi_a, busy_a, rx_rdy_a} !== 8'b1111_0000) begin
         n_fail++;
         $display("FAIL reset_ctl_a got %b want 11110000",
                  {cs_a, sclk_a, mosi_a, busy_a, rx_rdy_a});
      end
      n_run++;
      if (resp_a !== 8'h00 || resp_b !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_resp got %h/%h want 0", resp_a, resp_b);
      end
      n_run++;
      if ({cs_b, sclk_b, mosi_b, busy_b, rx_rdy_b} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_ctl_b got %b want 10000",
                  {cs_b, sclk_b, mosi_b, busy_b, rx_rdy_b});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_run++;
      if (busy_a !== 1'b0 || sclk_a !== 1'b0 || cs_a !== 4'hF) begin
         n_fail++;
         $display("FAIL idle_quiet got busy=%b sclk=%b cs=%b want 0 0 1111",
                  busy_a, sclk_a, cs_a);
      end
   endtask

   task automatic test_basic;
      int lat;
      xfer_a(1'b0, 8'hA5, 8'h3C, 0, 0, lat);
      n_run++;
      if (lat !== 67) begin
         n_fail++;
         $display("FAIL basic_latency got %0d want 67", lat);
      end
      n_run++;
      if (mlog_a !== 16'hA500) begin
         n_fail++;
         $display("FAIL basic_mosi got %h want a500", mlog_a);
      end
      n_run++;
      if (rise_a - rbase !== 16) begin
         n_fail++;
         $display("FAIL basic_sclk got %0d want 16", rise_a - rbase);
      end
      n_run++;
      if (resp_a !== 8'h3C) begin
         n_fail++;
         $display("FAIL basic_resp got %h want 3c", resp_a);
      end
      n_run++;
      if (cs_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_cs_low got %b want 1", cs_ok);
      end
      n_run++;
      if (cs_a !== 4'b1111 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_end got cs=%b busy=%b want 1111 0",
                  cs_a, busy_a);
      end
   endtask

   task automatic test_ignore_trmt;
      int lat;
      xfer_a(1'b0, 8'hA5, 8'h3C, 10, 40, lat);
      n_run++;
      if (rise_a - rbase !== 16) begin
         n_fail++;
         $display("FAIL ignore_sclk got %0d want 16", rise_a - rbase);
      end
      n_run++;
      if (busy_ok !== 1'b1 || lat !== 67) begin
         n_fail++;
         $display("FAIL ignore_busy got ok=%b lat=%0d want 1 67",
                  busy_ok, lat);
      end
      n_run++;
      if (mlog_a !== 16'hA500 || resp_a !== 8'h3C) begin
         n_fail++;
         $display("FAIL ignore_data got %h/%h want a500/3c",
                  mlog_a, resp_a);
      end
      repeat (4) @(posedge clk);
      #1;
      n_run++;
      if (busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_noqueue got busy=%b want 0", busy_a);
      end
   endtask

   task automatic test_wide;
      int lat;
      int rb;
      mw_b = 16'hBEEF;
      cmd_b = 16'h1234;
      rb = rise_b;
      @(posedge clk); #1;
      trmt_b = 1'b1;
      @(posedge clk); #1;
      trmt_b = 1'b0;
      cmd_b = 16'h0000;
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         if (rx_rdy_b) begin
            lat = i;
            break;
         end
      end
      n_run++;
      if (lat !== 66) begin
         n_fail++;
         $display("FAIL wide_latency got %0d want 66", lat);
      end
      n_run++;
      if (mlog_b !== 32'h1234_0000) begin
         n_fail++;
         $display("FAIL wide_mosi got %h want 12340000", mlog_b);
      end
      n_run++;
      if (rise_b - rb !== 32) begin
         n_fail++;
         $display("FAIL wide_sclk got %0d want 32", rise_b - rb);
      end
      n_run++;
      if (resp_b !== 16'hBEEF || cs_b !== 1'b1) begin
         n_fail++;
         $display("FAIL wide_resp got %h cs=%b want beef 1", resp_b, cs_b);
      end
   endtask

   task automatic test_cs_pulse;
      int lat;
      int hi;
      tie_clr = 1'b1;
      xfer_a(1'b0, 8'h5A, 8'h81, 0, 0, lat);
      hi = (lat > 0) ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (rx_rdy_a) hi++;
      end
      tie_clr = 1'b0;
      n_run++;
      if (hi !== 1) begin
         n_fail++;
         $display("FAIL pulse_width got %0d want 1", hi);
      end
      n_run++;
      if (cs_ok !== 1'b1 || cs_a !== 4'b1111) begin
         n_fail++;
         $display("FAIL pulse_cs got ok=%b cs=%b want 1 1111", cs_ok, cs_a);
      end
      n_run++;
      if (resp_a !== 8'h81) begin
         n_fail++;
         $display("FAIL pulse_resp got %h want 81", resp_a);
      end
   endtask

   task automatic test_set_wins;
      int lat;
      clr_drv = 1'b1;
      xfer_a(1'b0, 8'h0F, 8'h66, 0, 0, lat);
      n_run++;
      if (lat !== 67) begin
         n_fail++;
         $display("FAIL setwins_rise got %0d want 67", lat);
      end
      clr_drv = 1'b0;
      @(posedge clk); #1;
      n_run++;
      if (rx_rdy_a !== 1'b1) begin
         n_fail++;
         $display("FAIL setwins_sticky got %b want 1", rx_rdy_a);
      end
      clr_drv = 1'b1;
      xfer_a(1'b0, 8'hF0, 8'h99, 0, 0, lat);
      @(posedge clk); #1;
      n_run++;
      if (rx_rdy_a !== 1'b0 || lat !== 67) begin
         n_fail++;
         $display("FAIL setwins_held got rdy=%b lat=%0d want 0 67",
                  rx_rdy_a, lat);
      end
      clr_drv = 1'b0;
   endtask

   task automatic test_async_reset;
      int lat;
      mw_a = 8'hFF;
      cmd_a = 8'h77;
      @(posedge clk); #1;
      trmt_a = 1'b1;
      @(posedge clk); #1;
      trmt_a = 1'b0;
      repeat (45) @(posedge clk);
      #1;
      n_run++;
      if (busy_a !== 1'b1 || cs_a !== 4'b1011) begin
         n_fail++;
         $display("FAIL arst_pre got busy=%b cs=%b want 1 1011", busy_a, cs_a);
      end
      #3;
      rst_n = 1'b0;
      #1;
      n_run++;
      if ({cs_a, sclk_a, mosi_a, busy_a, rx_rdy_a} !== 8'b1111_0000) begin
         n_fail++;
         $display("FAIL arst_ctl got %b want 11110000",
                  {cs_a, sclk_a, mosi_a, busy_a, rx_rdy_a});
      end
      n_run++;
      if (resp_a !== 8'h00) begin
         n_fail++;
         $display("FAIL arst_resp got %h want 00", resp_a);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      xfer_a(1'b0, 8'hC3, 8'h99, 0, 0, lat);
      n_run++;
      if (lat !== 67 || resp_a !== 8'h99 || mlog_a !== 16'hC300) begin
         n_fail++;
         $display("FAIL arst_after got lat=%0d resp=%h mosi=%h want 67 99 c300",
                  lat, resp_a, mlog_a);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      xfer_a(1'b0, 8'h11, 8'h22, 0, 0, lat);
      n_run++;
      if (lat !== 67 || resp_a !== 8'h22) begin
         n_fail++;
         $display("FAIL b2b_first got lat=%0d resp=%h want 67 22", lat, resp_a);
      end
      xfer_a(1'b1, 8'h80, 8'hE7, 0, 0, lat);
      n_run++;
      if (lat !== 67 || resp_a !== 8'hE7) begin
         n_fail++;
         $display("FAIL b2b_second got lat=%0d resp=%h want 67 e7",
                  lat, resp_a);
      end
      n_run++;
      if (mlog_a !== 16'h8000) begin
         n_fail++;
         $display("FAIL b2b_mosi got %h want 8000", mlog_a);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignore_trmt();
      test_wide();
      test_cs_pulse();
      test_set_wins();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
